// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store memory sequencer.
package mem_pkg;

  // Number of byte lanes on the data memory port; lane 0 is the MSB byte.
  localparam int LANES  = 4;
  localparam int WORD_W = 32;
  // Wide enough for MEM_LAT-1 with MEM_LAT up to 15.
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Halfwords need addr[0]=0, words need addr[1:0]=0, size 3 is never legal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Big-endian lane steering: merges store data into a read word and
// extracts/extends load data out of it. Purely combinational.
module mem_lane_mux
  import mem_pkg::*;
(
  input  logic [7:0]        lanes_in  [0:LANES-1],
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [WORD_W-1:0] wdata,
  output logic [7:0]        lanes_out [0:LANES-1],
  output logic [WORD_W-1:0] rdata
);

  logic [1:0]        hi_idx;
  logic [1:0]        lo_idx;
  logic [WORD_W-1:0] ext;

  // Lane merge for stores and lane extract plus extension for loads.
  always_comb begin
    hi_idx    = {addr_lo[1], 1'b0};
    lo_idx    = {addr_lo[1], 1'b1};
    lanes_out = lanes_in;
    ext       = '0;
    case (size)
      SZ_BYTE: begin
        lanes_out[addr_lo] = wdata[7:0];
        ext = {{24{is_signed & lanes_in[addr_lo][7]}}, lanes_in[addr_lo]};
      end
      SZ_HALF: begin
        lanes_out[hi_idx] = wdata[15:8];
        lanes_out[lo_idx] = wdata[7:0];
        ext = {{16{is_signed & lanes_in[hi_idx][7]}},
               lanes_in[hi_idx], lanes_in[lo_idx]};
      end
      default: begin
        // Word (illegal size never reaches memory, so its result is unused).
        for (int i = 0; i < LANES; i++) begin
          lanes_out[i] = wdata[8*(LANES-1-i) +: 8];
        end
        ext = {lanes_in[0], lanes_in[1], lanes_in[2], lanes_in[3]};
      end
    endcase
  end

  assign rdata = ext;

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle sequencer between the core load/store path and a 4-lane
// word-wide data memory. Sub-word stores are done as read-modify-write.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [7:0]      mem_data_in  [0:LANES-1],
  input  logic [7:0]      mem_data_out [0:LANES-1],
  output logic            mem_write_en
);

  state_e            state;
  state_e            state_nx;
  logic [CNT_W-1:0]  cnt;

  // Request fields captured at the accept edge.
  logic [1:0]        addr_lo_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic              write_q;
  logic [XLEN-1:0]   wdata_q;

  logic              accept;
  logic              acc_err;
  logic              acc_word_st;
  logic              in_idle;

  logic [1:0]        mux_addr_lo;
  logic [1:0]        mux_size;
  logic              mux_sign;
  logic [WORD_W-1:0] mux_wdata;
  logic [7:0]        mux_lanes [0:LANES-1];
  logic [WORD_W-1:0] mux_rdata;

  assign in_idle     = (state == IDLE);
  assign accept      = req_valid && in_idle;
  assign acc_err     = is_misaligned(req_size, req_addr[1:0]);
  assign acc_word_st = req_write && (req_size == SZ_WORD);

  // In IDLE the lane mux sees the live request (word stores build their
  // write data at the accept edge); afterwards it sees the latched request.
  assign mux_addr_lo = in_idle ? req_addr[1:0]          : addr_lo_q;
  assign mux_size    = in_idle ? req_size               : size_q;
  assign mux_sign    = in_idle ? req_signed             : sign_q;
  assign mux_wdata   = in_idle ? req_wdata[WORD_W-1:0]  : wdata_q[WORD_W-1:0];

  mem_lane_mux u_lane_mux (
    .lanes_in  (mem_data_out),
    .addr_lo   (mux_addr_lo),
    .size      (mux_size),
    .is_signed (mux_sign),
    .wdata     (mux_wdata),
    .lanes_out (mux_lanes),
    .rdata     (mux_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode and per-state handshake/strobe outputs.
  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_write_en = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err) begin
            state_nx = RESP;
          end else if (acc_word_st) begin
            state_nx = WR;
          end else begin
            state_nx = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_nx = write_q ? WR : RESP;
        end
      end
      WR: begin
        mem_write_en = 1'b1;
        state_nx     = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request capture; only meaningful after an accept, so left unreset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_lo_q <= req_addr[1:0];
      size_q    <= req_size;
      sign_q    <= req_signed;
      write_q   <= req_write;
      wdata_q   <= req_wdata;
    end
  end

  // Latency counter, memory address/write lanes and response registers.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      cnt       <= '0;
      mem_addr  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        mem_data_in[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (acc_err) begin
              // Rejected requests leave the memory port untouched.
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[XLEN-1:2], 2'b00};
              cnt      <= CNT_W'(MEM_LAT - 1);
              if (acc_word_st) begin
                mem_data_in <= mux_lanes;
              end
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            if (write_q) begin
              mem_data_in <= mux_lanes;
            end else begin
              rsp_rdata <= XLEN'(mux_rdata);
              rsp_err   <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: instance A with MEM_LAT=1, instance B
// with MEM_LAT=3, each backed by a small behavioural word memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid_a, req_valid_b;
  logic        req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, mwe_a;
  logic [31:0] rsp_rdata_a, mem_addr_a;
  logic [7:0]  mdi_a [0:3];
  logic [7:0]  mdo_a [0:3];

  logic        req_ready_b, rsp_valid_b, rsp_err_b, mwe_b;
  logic [31:0] rsp_rdata_b, mem_addr_b;
  logic [7:0]  mdi_b [0:3];
  logic [7:0]  mdo_b [0:3];

  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [9:0]  pb1, pb2;
  logic [31:0] win_a, win_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.XLEN(32), .MEM_LAT(1)) dut_a (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_a),
    .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a), .mem_addr(mem_addr_a),
    .mem_data_in(mdi_a), .mem_data_out(mdo_a), .mem_write_en(mwe_a)
  );

  mem_access_ctrl #(.XLEN(32), .MEM_LAT(3)) dut_b (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid_b),
    .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .mem_addr(mem_addr_b),
    .mem_data_in(mdi_b), .mem_data_out(mdo_b), .mem_write_en(mwe_b)
  );

  assign win_a = {mdi_a[0], mdi_a[1], mdi_a[2], mdi_a[3]};
  assign win_b = {mdi_b[0], mdi_b[1], mdi_b[2], mdi_b[3]};

  // Memory A: read data follows the address immediately (fits MEM_LAT=1).
  always @* begin
    for (int i = 0; i < 4; i++) mdo_a[i] = mem_a[mem_addr_a[11:2]][8*(3-i) +: 8];
  end

  // Memory B: read data appears two edges after the address changes, so it
  // is only correct when sampled at the third edge (MEM_LAT=3).
  always @(posedge clk) begin
    pb1 <= mem_addr_b[11:2];
    pb2 <= pb1;
  end
  always @* begin
    for (int i = 0; i < 4; i++) mdo_b[i] = mem_b[pb2][8*(3-i) +: 8];
  end

  always @(posedge clk) begin
    if (mwe_a) mem_a[mem_addr_a[11:2]] = win_a;
    if (mwe_b) mem_b[mem_addr_b[11:2]] = win_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, then watch until the response pulse (bounded).
  task automatic run_req(input bit inst, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int we_n, output int we_at, output logic [31:0] we_word);
    lat = 0; rd = '0; er = 1'b0; we_n = 0; we_at = 0; we_word = '0;
    req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    if (inst) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (inst ? mwe_b : mwe_a) begin
        we_n++; we_at = c; we_word = inst ? win_b : win_a;
      end
      if (inst ? rsp_valid_b : rsp_valid_a) begin
        lat = c;
        rd  = inst ? rsp_rdata_b : rsp_rdata_a;
        er  = inst ? rsp_err_b : rsp_err_a;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  initial begin : main
    int          lat, we_n, we_at, seen;
    logic [31:0] rd, we_word, rd1, rd2;
    logic        er;
    logic [10:1] rdy_v, rsp_v;

    for (int i = 0; i < 1024; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[32'h100 >> 2] = 32'h8012F345;
    mem_b[32'h300 >> 2] = 32'h11223344;
    mem_b[32'h304 >> 2] = 32'hA1B2C3D4;
    req_valid_a = 0; req_valid_b = 0; req_write = 0; req_signed = 0;
    req_size = 0; req_addr = 0; req_wdata = 0;

    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_b = 1'b0;
    chk("rst_ready", {31'd0, req_ready_a}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err_a}, 32'd0);
    chk("rst_rdata", rsp_rdata_a, 32'd0);
    chk("rst_we", {31'd0, mwe_a}, 32'd0);
    chk("rst_mem_addr", mem_addr_a, 32'd0);
    chk("rst_lanes", win_a, 32'd0);

    // Loads on word 0x100 = {80,12,F3,45}, MEM_LAT=1
    run_req(0, 0, 2'd0, 1, 32'h102, 0, lat, rd, er, we_n, we_at, we_word);
    chk("lb_lat", lat, 2); chk("lb_data", rd, 32'hFFFFFFF3); chk("lb_err", {31'd0, er}, 0);
    run_req(0, 0, 2'd0, 0, 32'h102, 0, lat, rd, er, we_n, we_at, we_word);
    chk("lbu_data", rd, 32'h000000F3);
    run_req(0, 0, 2'd0, 1, 32'h100, 0, lat, rd, er, we_n, we_at, we_word);
    chk("lb0_data", rd, 32'hFFFFFF80);
    run_req(0, 0, 2'd1, 1, 32'h100, 0, lat, rd, er, we_n, we_at, we_word);
    chk("lh_data", rd, 32'hFFFF8012);
    run_req(0, 0, 2'd1, 0, 32'h102, 0, lat, rd, er, we_n, we_at, we_word);
    chk("lhu_data", rd, 32'h0000F345);
    run_req(0, 0, 2'd2, 1, 32'h100, 0, lat, rd, er, we_n, we_at, we_word);
    chk("lw_data", rd, 32'h8012F345); chk("lw_we", we_n, 0);

    // Sub-word store: read-modify-write
    run_req(0, 1, 2'd0, 0, 32'h101, 32'h000000AA, lat, rd, er, we_n, we_at, we_word);
    chk("sb_lat", lat, 3); chk("sb_we_n", we_n, 1); chk("sb_lanes", we_word, 32'h80AAF345);
    chk("sb_rdata", rd, 0);
    run_req(0, 0, 2'd2, 0, 32'h100, 0, lat, rd, er, we_n, we_at, we_word);
    chk("sb_readback", rd, 32'h80AAF345);

    // Word store, then halfword merge into it
    run_req(0, 1, 2'd2, 0, 32'h200, 32'hDEADBEEF, lat, rd, er, we_n, we_at, we_word);
    chk("sw_lat", lat, 2); chk("sw_we_at", we_at, 1); chk("sw_we_n", we_n, 1);
    chk("sw_lanes", we_word, 32'hDEADBEEF);
    run_req(0, 1, 2'd1, 0, 32'h202, 32'h00001234, lat, rd, er, we_n, we_at, we_word);
    chk("sh_lat", lat, 3); chk("sh_lanes", we_word, 32'hDEAD1234);
    run_req(0, 0, 2'd2, 0, 32'h200, 0, lat, rd, er, we_n, we_at, we_word);
    chk("sh_readback", rd, 32'hDEAD1234);

    // Misaligned / illegal requests
    run_req(0, 0, 2'd2, 0, 32'h103, 0, lat, rd, er, we_n, we_at, we_word);
    chk("lw_mis_lat", lat, 1); chk("lw_mis_err", {31'd0, er}, 1); chk("lw_mis_rdata", rd, 0);
    run_req(0, 1, 2'd1, 0, 32'h201, 32'h5555, lat, rd, er, we_n, we_at, we_word);
    chk("sh_mis_lat", lat, 1); chk("sh_mis_err", {31'd0, er}, 1); chk("sh_mis_we", we_n, 0);
    run_req(0, 0, 2'd3, 0, 32'h100, 0, lat, rd, er, we_n, we_at, we_word);
    chk("sz3_lat", lat, 1); chk("sz3_err", {31'd0, er}, 1); chk("sz3_rdata", rd, 0);
    chk("err_mem_addr", mem_addr_a, 32'h200);
    run_req(0, 0, 2'd2, 0, 32'h200, 0, lat, rd, er, we_n, we_at, we_word);
    chk("err_clear", {31'd0, er}, 0);

    // Reset during RD_WAIT of a sub-word store drops the write
    req_write = 1; req_size = 2'd0; req_signed = 0; req_addr = 32'h100; req_wdata = 32'h55;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    chk("mid_in_rdwait", {31'd0, req_ready_a}, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    chk("mid_ready", {31'd0, req_ready_a}, 1);
    chk("mid_we", {31'd0, mwe_a}, 0);
    chk("mid_mem_addr", mem_addr_a, 0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid_a || mwe_a) seen++;
      @(posedge clk); #1;
    end
    chk("mid_quiet", seen, 0);
    run_req(0, 0, 2'd2, 0, 32'h100, 0, lat, rd, er, we_n, we_at, we_word);
    chk("mid_no_write", rd, 32'h80AAF345);

    // MEM_LAT=3, back-to-back loads with req_valid held high
    rd1 = '0; rd2 = '0;
    req_write = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h300;
    req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h304;
    for (int c = 1; c <= 10; c++) begin
      rdy_v[c] = req_ready_b;
      rsp_v[c] = rsp_valid_b;
      if (rsp_valid_b) begin
        if (c < 6) rd1 = rsp_rdata_b; else rd2 = rsp_rdata_b;
      end
      if (c == 6) req_valid_b = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_ready", {22'd0, rdy_v}, 32'b1000010000);
    chk("b2b_rsp", {22'd0, rsp_v}, 32'b0100001000);
    chk("b2b_data1", rd1, 32'h11223344);
    chk("b2b_data2", rd2, 32'hA1B2C3D4);
    run_req(1, 0, 2'd0, 0, 32'h305, 0, lat, rd, er, we_n, we_at, we_word);
    chk("l3_lbu_lat", lat, 4); chk("l3_lbu_data", rd, 32'h000000B2);
    run_req(1, 0, 2'd1, 1, 32'h306, 0, lat, rd, er, we_n, we_at, we_word);
    chk("l3_lh_data", rd, 32'hFFFFC3D4);
    run_req(1, 1, 2'd0, 0, 32'h301, 32'h77, lat, rd, er, we_n, we_at, we_word);
    chk("l3_sb_lat", lat, 5); chk("l3_sb_lanes", we_word, 32'h11773344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
